scomp_program_loader: RTL and testbench

//  Upstream stage of the simple computer. Receives a framed byte stream (UART RX or host

---
 rtl/scomp_pkg.sv | 24 ++
 rtl/scomp_loader_wordpack.sv | 49 ++++
 rtl/scomp_program_loader.sv | 128 ++++++++++++
 tb/tb_scomp_program_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scomp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scomp_pkg : memory geometry, sync marker and loader state encoding        |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package scomp_pkg;

  localparam int         SCOMP_ADDR_W    = 8;
  localparam int         SCOMP_DATA_W    = 16;
  localparam logic [7:0] SCOMP_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_COUNT = 3'd1,
    LD_HI    = 3'd2,
    LD_LO    = 3'd3,
    LD_WRITE = 3'd4,
    LD_CHECK = 3'd5,
    LD_DONE  = 3'd6,
    LD_ERROR = 3'd7
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/scomp_loader_wordpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scomp_loader_wordpack : hi/lo byte capture into a 16-bit word; running    |
// | checksum when SCOMP_LOADER_CHECKSUM_EN is defined                         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module scomp_loader_wordpack
  import scomp_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hi_en,
  input  logic                    lo_en,
`ifdef SCOMP_LOADER_CHECKSUM_EN
  input  logic                    clear,
  output logic                    sum_ok,
`endif
  input  logic [7:0]              data_in,
  output logic [SCOMP_DATA_W-1:0] word
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word <= '0;
    end else begin
      if (hi_en) word[SCOMP_DATA_W-1:8] <= data_in;
      if (lo_en) word[7:0]              <= data_in;
    end
  end

`ifdef SCOMP_LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (hi_en || lo_en) begin
      sum <= sum + data_in;
    end
  end

  // Evaluated against the byte on the bus, i.e. the trailing checksum byte.
  assign sum_ok = ((sum + data_in) == 8'h00);
`endif

endmodule
`default_nettype wire

// File: rtl/scomp_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scomp_program_loader : framed byte stream -> 256x16 program memory,       |
// | holds the CPU in reset until an image loads. Option: SCOMP_LOADER_CHECKSUM_EN |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module scomp_program_loader
  import scomp_pkg::*;
#(
  parameter int                ADDR_W     = SCOMP_ADDR_W,
  parameter int                DATA_W     = SCOMP_DATA_W,
  parameter logic [7:0]        SYNC_BYTE  = SCOMP_SYNC_BYTE,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t    state;
  loader_state_t    next_state;
  logic [CNT_W-1:0] word_cnt;
  logic             accept;
  logic             start;
  logic             last_word;
  logic             hi_en;
  logic             lo_en;
`ifdef SCOMP_LOADER_CHECKSUM_EN
  logic             sum_ok;
`endif

  assign rx_ready  = (state != LD_WRITE);
  assign mem_wren  = (state == LD_WRITE);
  assign accept    = rx_valid && rx_ready;
  assign start     = accept && (rx_data == SYNC_BYTE) &&
                     (state inside {LD_IDLE, LD_DONE, LD_ERROR});
  assign last_word = (word_cnt == CNT_W'(1));
  assign hi_en     = accept && (state == LD_HI);
  assign lo_en     = accept && (state == LD_LO);

  scomp_loader_wordpack u_wordpack (
    .clock   (clock),
    .reset   (reset),
    .hi_en   (hi_en),
    .lo_en   (lo_en),
`ifdef SCOMP_LOADER_CHECKSUM_EN
    .clear   (start),
    .sum_ok  (sum_ok),
`endif
    .data_in (rx_data),
    .word    (mem_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      LD_IDLE, LD_DONE, LD_ERROR: if (start) next_state = LD_COUNT;
      LD_COUNT: if (accept) next_state = LD_HI;
      LD_HI:    if (accept) next_state = LD_LO;
      LD_LO:    if (accept) next_state = LD_WRITE;
      LD_WRITE: begin
        if (!last_word) begin
          next_state = LD_HI;
        end else begin
`ifdef SCOMP_LOADER_CHECKSUM_EN
          next_state = LD_CHECK;
`else
          next_state = LD_DONE;
`endif
        end
      end
`ifdef SCOMP_LOADER_CHECKSUM_EN
      LD_CHECK: if (accept) next_state = sum_ok ? LD_DONE : LD_ERROR;
`endif
      default:  next_state = LD_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LD_IDLE;
      word_cnt  <= '0;
      mem_addr  <= START_ADDR;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
    end else begin
      state     <= next_state;
      // Status follows the state one cycle later.
      cpu_reset <= (state != LD_DONE);
      load_done <= (state == LD_DONE);
      if (start) begin
        mem_addr <= START_ADDR;
      end else if (state == LD_WRITE) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      // A count byte of zero means a full 256-word image.
      if ((state == LD_COUNT) && accept) begin
        word_cnt <= (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
      end else if (state == LD_WRITE) begin
        word_cnt <= word_cnt - CNT_W'(1);
      end
    end
  end

`ifdef SCOMP_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_error <= 1'b0;
    end else begin
      load_error <= (state == LD_ERROR);
    end
  end
`else
  assign load_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scomp_program_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scomp_program_loader : frame-level model of the program loader         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scomp_program_loader;

  localparam logic [7:0] START = 8'hFE;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef SCOMP_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clock    = 1'b0;
  logic        reset    = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_ready;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int          total = 0;
  int          bad   = 0;
  bit          gaps  = 1'b0;
  logic [23:0] exp_q[$];
  logic [7:0]  payload[$];
  logic [23:0] exp_wr;

  always #5 clock = ~clock;

  scomp_program_loader #(.START_ADDR(START)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the next word the model expects.
  always @(negedge clock) begin
    if (!reset) begin
      check_eq("ready_vs_wren", rx_ready, !mem_wren);
      if (mem_wren) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_wren", mem_wren, 1'b0);
        end else begin
          exp_wr = exp_q.pop_front();
          check_eq("wr_addr", mem_addr, exp_wr[23:16]);
          check_eq("wr_data", mem_data, exp_wr[15:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (gaps) idle($urandom_range(0, 2));
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 20) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 20) check_eq("ready_timeout", rx_ready, 1'b1);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic fill(input int words);
    payload.delete();
    for (int i = 0; i < 2 * words; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_frame(input logic [7:0] n_field, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] addr;
    sum  = 8'h00;
    addr = START;
    send_byte(SYNC);
    send_byte(n_field);
    check_eq("cpu_reset_after_sync", cpu_reset, 1'b1);
    check_eq("done_clear_after_sync", load_done, 1'b0);
    for (int i = 0; i < payload.size(); i += 2) begin
      exp_q.push_back({addr, payload[i], payload[i+1]});
      addr = addr + 8'd1;
      sum  = sum + payload[i] + payload[i+1];
      send_byte(payload[i]);
      send_byte(payload[i+1]);
    end
    if (CK_EN) send_byte(8'(8'h00 - sum) + (corrupt ? 8'd1 : 8'd0));
  endtask

  task automatic expect_status(input bit corrupt);
    bit err;
    err = corrupt && CK_EN;
    idle(4);
    check_eq("cpu_reset", cpu_reset, err);
    check_eq("load_done", load_done, !err);
    check_eq("load_error", load_error, err);
    check_eq("writes_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check_eq("rst_rx_ready", rx_ready, 1'b1);
    check_eq("rst_mem_addr", mem_addr, START);
    check_eq("rst_mem_data", mem_data, 16'h0000);
    check_eq("rst_mem_wren", mem_wren, 1'b0);
    check_eq("rst_cpu_reset", cpu_reset, 1'b1);
    check_eq("rst_load_done", load_done, 1'b0);
    check_eq("rst_load_error", load_error, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit corrupt;
    int n;
    reset = 1'b1;
    idle(3);
    check_reset_values();
    reset = 1'b0;
    idle(2);

    // Fixed two-word image.
    payload.delete();
    payload.push_back(8'h12); payload.push_back(8'h34);
    payload.push_back(8'hAB); payload.push_back(8'hCD);
    send_frame(8'd2, 1'b0);
    expect_status(1'b0);

    // Bad checksum, then a valid resend.
    payload.delete();
    payload.push_back(8'h00); payload.push_back(8'h05);
    send_frame(8'd1, 1'b1);
    expect_status(1'b1);
    fill(1);
    send_frame(8'd1, 1'b0);
    expect_status(1'b0);

    // Junk while loaded is dropped.
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h00);
    expect_status(1'b0);

    // Full 256-word image, address wraps through the whole space.
    fill(256);
    send_frame(8'd0, 1'b0);
    expect_status(1'b0);

    // Three words from FE wrap to 00.
    fill(3);
    send_frame(8'd3, 1'b0);
    expect_status(1'b0);

    // Sync value as payload, then reset mid-frame.
    send_byte(SYNC);
    send_byte(8'd5);
    exp_q.push_back({START, 8'hA5, 8'h00});
    send_byte(8'hA5); send_byte(8'h00);
    exp_q.push_back({START + 8'd1, 8'h5A, 8'hA5});
    send_byte(8'h5A); send_byte(8'hA5);
    send_byte(8'h77);
    reset = 1'b1;
    idle(2);
    check_reset_values();
    reset = 1'b0;
    idle(1);
    send_byte(8'h03); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    idle(3);
    check_reset_values();
    check_eq("reset_writes_drained", exp_q.size(), 0);
    fill(2);
    send_frame(8'd2, 1'b0);
    expect_status(1'b0);

    // Random gaps, back-to-back frames.
    gaps = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 6);
      corrupt = ((k % 2) == 1) && ($urandom_range(0, 1) == 1);
      fill(n);
      send_frame(8'(n), corrupt);
      if ((k % 2) == 1) expect_status(corrupt);
    end
    gaps = 1'b0;

    idle(4);
    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
